// File: rtl/shift_issue_arbiter_pkg.sv
// Shared execution-unit definitions: operand widths, shift op encodings and
// the request record that the arbiter muxes onto the shared shifter.
package shift_issue_arbiter_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int IMMEDIATE_WIDTH  = 12;
  localparam int CTRL_SHIFT_WIDTH = 3;
  localparam int SHAMT_WIDTH      = 5;
  localparam int SHIFT_TAG_WIDTH  = 5;

  typedef enum logic [CTRL_SHIFT_WIDTH-1:0] {
    CTRL_SLL  = 3'd0,
    CTRL_SRL  = 3'd1,
    CTRL_SRA  = 3'd2,
    CTRL_SLLI = 3'd3,
    CTRL_SRLI = 3'd4,
    CTRL_SRAI = 3'd5
  } shift_ctrl_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]       src1;
    logic [DATA_WIDTH-1:0]       src2;
    logic [IMMEDIATE_WIDTH-1:0]  imm;
    logic [CTRL_SHIFT_WIDTH-1:0] ctrl;
    logic [SHIFT_TAG_WIDTH-1:0]  tag;
  } shift_req_t;

endpackage

// File: rtl/shift_issue_arbiter_shifter.sv
// Combinational barrel shifter shared by both issue pipes. Register forms take
// the amount from src2[4:0], immediate forms from imm (already limited to 0..31
// by the caller). Unrecognised ops pass src1 through unchanged.
module shift_issue_arbiter_shifter
  import shift_issue_arbiter_pkg::*;
(
  input  logic                        uop_is_shift,
  input  logic [DATA_WIDTH-1:0]       src1,
  input  logic [DATA_WIDTH-1:0]       src2,
  input  logic [IMMEDIATE_WIDTH-1:0]  imm,
  input  logic [CTRL_SHIFT_WIDTH-1:0] ctrl,
  output logic [DATA_WIDTH-1:0]       result
);

  logic [SHAMT_WIDTH-1:0] shamt_reg;
  logic [DATA_WIDTH-1:0]  shifted;
  logic                   unused_src2_bits;

  assign unused_src2_bits = ^src2[DATA_WIDTH-1:SHAMT_WIDTH];

  // Decode the op and shift; result is zero when no uop is issued this cycle
  always_comb begin
    shamt_reg = src2[SHAMT_WIDTH-1:0];
    shifted   = src1;
    case (ctrl)
      CTRL_SLL:  shifted = src1 << shamt_reg;
      CTRL_SRL:  shifted = src1 >> shamt_reg;
      CTRL_SRA:  shifted = $unsigned($signed(src1) >>> shamt_reg);
      CTRL_SLLI: shifted = src1 << imm;
      CTRL_SRLI: shifted = src1 >> imm;
      CTRL_SRAI: shifted = $unsigned($signed(src1) >>> imm);
      default:   shifted = src1;
    endcase
    result = uop_is_shift ? shifted : '0;
  end

endmodule

// File: rtl/shift_issue_arbiter.sv
// Round-robin arbiter sharing one shifter between two issue pipes. At most one
// uop is accepted per cycle; its result, tag and source pipe are captured in a
// one-entry output buffer that holds until writeback takes it.
module shift_issue_arbiter
  import shift_issue_arbiter_pkg::*;
#(
  parameter int TAG_WIDTH = SHIFT_TAG_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [1:0][DATA_WIDTH-1:0]       req_src1,
  input  logic [1:0][DATA_WIDTH-1:0]       req_src2,
  input  logic [1:0][IMMEDIATE_WIDTH-1:0]  req_imm,
  input  logic [1:0][CTRL_SHIFT_WIDTH-1:0] req_ctrl,
  input  logic [1:0][TAG_WIDTH-1:0]        req_tag,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [DATA_WIDTH-1:0]            wb_data,
  output logic [TAG_WIDTH-1:0]             wb_tag,
  output logic                             wb_pipe
);

  logic                  rr_ptr_q, rr_ptr_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;
  logic                  wb_pipe_q, wb_pipe_d;

  logic                  can_accept;
  logic                  gnt_any;
  logic                  gnt_pipe;
  logic                  accept;
  shift_req_t            sel_req;
  logic [DATA_WIDTH-1:0] result_shifter;
  logic                  unused_imm_bits;

  // Only the low shift-amount bits of the immediate are meaningful here
  assign unused_imm_bits = ^{req_imm[0][IMMEDIATE_WIDTH-1:SHAMT_WIDTH],
                             req_imm[1][IMMEDIATE_WIDTH-1:SHAMT_WIDTH]};

  // Pick a pipe: a lone requester wins, on contention rr_ptr decides
  always_comb begin
    can_accept = !wb_valid_q || wb_ready;
    gnt_any    = |req_valid;
    gnt_pipe   = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    req_ready  = 2'b00;
    if (gnt_any && can_accept && !flush && !reset) begin
      req_ready[gnt_pipe] = 1'b1;
    end
    accept = |(req_valid & req_ready);
  end

  // Mux the granted pipe's operands; mask imm so SRAI's funct7 bit never shifts
  always_comb begin
    sel_req.src1 = req_src1[gnt_pipe];
    sel_req.src2 = req_src2[gnt_pipe];
    sel_req.imm  = IMMEDIATE_WIDTH'(req_imm[gnt_pipe][SHAMT_WIDTH-1:0]);
    sel_req.ctrl = req_ctrl[gnt_pipe];
    sel_req.tag  = SHIFT_TAG_WIDTH'(req_tag[gnt_pipe]);
  end

  shift_issue_arbiter_shifter u_shifter (
    .uop_is_shift (accept),
    .src1         (sel_req.src1),
    .src2         (sel_req.src2),
    .imm          (sel_req.imm),
    .ctrl         (sel_req.ctrl),
    .result       (result_shifter)
  );

  // Next-state: flush beats accept beats drain; accept+drain refills with no bubble
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    wb_pipe_d  = wb_pipe_q;
    if (accept) begin
      rr_ptr_d = ~gnt_pipe;
    end
    if (flush) begin
      wb_valid_d = 1'b0;
    end else if (accept) begin
      wb_valid_d = 1'b1;
      wb_data_d  = result_shifter;
      wb_tag_d   = TAG_WIDTH'(sel_req.tag);
      wb_pipe_d  = gnt_pipe;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      wb_pipe_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      wb_pipe_q  <= wb_pipe_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_tag   = wb_tag_q;
  assign wb_pipe  = wb_pipe_q;

endmodule
